// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
package pwm_pkg;

  // Default phase-count width, common to pwm (hi/lo inputs) and pwm_capture.
  localparam int unsigned PWM_WIDTH = 8;

  // Phase-tracking states of the capture FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_sync_edge.sv
// Synchroniser for an asynchronous PWM input.
// Also provides one extra delay flop for rising/falling edge detection.
module pwm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic s_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  // Shift the raw input through the synchroniser chain, then delay once more.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value; a blocking chain would collapse into a single stage.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = s_o & ~s_d_q;
  assign fall_o = ~s_o & s_d_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures the high/low phase widths of a PWM waveform in clk cycles and
// reports each completed period (rising edge to rising edge).
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             pwm_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             valid_o,
  output logic             ovf_o,
  output logic             stuck_o
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic s, rise, fall;

  pwm_state_e       state_q,  state_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] lo_cnt_q, lo_cnt_d;
  logic [WIDTH-1:0] hi_q,     hi_d;
  logic [WIDTH-1:0] lo_q,     lo_d;
  logic             ovf_q,    ovf_d;
  logic             valid_q,  valid_d;
  logic             stuck_q,  stuck_d;

  pwm_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .d_i    (pwm_i),
    .s_o    (s),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Next-state logic: phase FSM, saturating counters and report capture.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    hi_cnt_d = hi_cnt_q;
    lo_cnt_d = lo_cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;

    if (!en) begin
      // Disable wins over any edge; the partial period is dropped.
      state_d  = ST_IDLE;
      hi_cnt_d = '0;
      lo_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (rise) begin
            state_d  = ST_HIGH;
            hi_cnt_d = CNT_ONE;
            lo_cnt_d = '0;
          end
        end
        ST_HIGH: begin
          if (fall) begin
            state_d  = ST_LOW;
            lo_cnt_d = CNT_ONE;
          end else if (s && hi_cnt_q != CNT_MAX) begin
            hi_cnt_d = hi_cnt_q + 1'b1;
          end
        end
        ST_LOW: begin
          if (rise) begin
            hi_d     = hi_cnt_q;
            lo_d     = lo_cnt_q;
            ovf_d    = (hi_cnt_q == CNT_MAX) || (lo_cnt_q == CNT_MAX);
            valid_d  = 1'b1;
            state_d  = ST_HIGH;
            hi_cnt_d = CNT_ONE;
          end else if (!s && lo_cnt_q != CNT_MAX) begin
            lo_cnt_d = lo_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          hi_cnt_d = '0;
          lo_cnt_d = '0;
        end
      endcase
    end

    // Registered view of "active-phase counter saturated", aligned with it.
    stuck_d = ((state_d == ST_HIGH) && (hi_cnt_d == CNT_MAX)) ||
              ((state_d == ST_LOW)  && (lo_cnt_d == CNT_MAX));
  end

  // State, counter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hi_cnt_q <= '0;
      lo_cnt_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_cnt_q <= hi_cnt_d;
      lo_cnt_q <= lo_cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign ovf_o   = ovf_q;
  assign valid_o = valid_q;
  assign stuck_o = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: the stimulus pushes expected reports,
// a monitor pops and compares them on every valid_o strobe.
module tb_pwm_capture;

  localparam int WIDTH = 8;

  typedef struct {
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             en;
  logic             pwm_i;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             valid_o;
  logic             ovf_o;
  logic             stuck_o;

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  exp_t sb_q[$];

  pwm_capture #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .pwm_i   (pwm_i),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .valid_o (valid_o),
    .ovf_o   (ovf_o),
    .stuck_o (stuck_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One PWM period driven cycle-aligned; optionally expect it to be reported.
  task automatic drive_period(input int hi, input int lo, input bit expect_rpt);
    exp_t e;
    if (expect_rpt) begin
      e.hi  = WIDTH'(hi);
      e.lo  = WIDTH'(lo);
      e.ovf = 1'b0;
      sb_q.push_back(e);
    end
    pwm_i = 1'b1;
    repeat (hi) @(negedge clk);
    pwm_i = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && valid_o) begin
      if (sb_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got hi=%0d lo=%0d ovf=%0d, expected no strobe",
                 hi_o, lo_o, ovf_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("report_hi",  32'(hi_o),  32'(e.hi));
        check("report_lo",  32'(lo_o),  32'(e.lo));
        check("report_ovf", 32'(ovf_o), 32'(e.ovf));
      end
    end
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    en    = 1'b0;
    pwm_i = 1'b0;

    // Reset state.
    #100;
    check("reset_hi",    32'(hi_o),    0);
    check("reset_lo",    32'(lo_o),    0);
    check("reset_valid", 32'(valid_o), 0);
    check("reset_ovf",   32'(ovf_o),   0);
    check("reset_stuck", 32'(stuck_o), 0);
    @(negedge clk);
    reset = 1'b0;

    // Disabled: toggling input produces no strobe (monitor flags any).
    for (int i = 0; i < 5; i++) drive_period(2, 2, 1'b0);
    repeat (5) @(negedge clk);
    check("disabled_hi", 32'(hi_o), 0);
    check("disabled_lo", 32'(lo_o), 0);

    // Enabled: 5/11 periods, then switch to 8/12.
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) drive_period(5, 11, 1'b1);
    for (int i = 0; i < 3; i++) drive_period(8, 12, 1'b1);

    // Minimum phases: 1 high, 1 low.
    for (int i = 0; i < 4; i++) drive_period(1, 1, 1'b1);

    // Held high for 300 cycles: saturation, stuck flag, overflowed report.
    e.hi  = 8'd255;
    e.lo  = 8'd4;
    e.ovf = 1'b1;
    sb_q.push_back(e);
    pwm_i = 1'b1;
    repeat (256) @(negedge clk);
    check("stuck_before_sat", 32'(stuck_o), 0);
    @(negedge clk);
    check("stuck_at_sat", 32'(stuck_o), 1);
    repeat (43) @(negedge clk);
    check("stuck_held", 32'(stuck_o), 1);
    pwm_i = 1'b0;
    repeat (4) @(negedge clk);
    check("stuck_cleared", 32'(stuck_o), 0);

    // A normal period closes the overflowed one, then en drops mid-LOW.
    drive_period(3, 3, 1'b1);
    pwm_i = 1'b1;
    repeat (4) @(negedge clk);
    pwm_i = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_hi",    32'(hi_o),    3);
    check("hold_lo",    32'(lo_o),    3);
    check("hold_stuck", 32'(stuck_o), 0);
    en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) drive_period(2, 8, 1'b1);
    // Closing rise for the last 2/8 period; this pulse itself stays open.
    drive_period(2, 20, 1'b0);

    // Bounded drain of outstanding expectations.
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures the high and low phase widths, in `clk` cycles, of a PWM waveform: either a `pwm_o` output looped back or an external PWM input. It reports each completed period as a `hi_o`/`lo_o` pair in the same encoding that the `pwm` generator accepts on its `hi`/`lo` inputs. It sits directly downstream of `pwm`. Uses: closed-loop self-check of the generator, and capture of external PWM sources for re-generation.

## Interface
- `WIDTH`, 8: width of the phase counters and of `hi_o`/`lo_o`; matches the `pwm` `hi`/`lo` width.
- `SYNC_STAGES`, 2: number of synchroniser flops on `pwm_i`; legal range ≥2.
- `clk` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `en` in 1: capture enable; when low the block is held idle.
- `pwm_i` in 1: PWM waveform; treated as asynchronous.
- `hi_o` out WIDTH: high-phase cycle count of the last completed period.
- `lo_o` out WIDTH: low-phase cycle count of the last completed period.
- `valid_o` out 1: one-cycle strobe; `hi_o`/`lo_o`/`ovf_o` are updated in the same cycle.
- `ovf_o` out 1: the last reported period had a saturated phase count.
- `stuck_o` out 1: the current phase counter is saturated, i.e. no edge has arrived for 2^WIDTH−1 cycles.

## Operation
- `pwm_i` passes through `SYNC_STAGES` flops to give `s`. One further flop gives `s_d`.
  - `rise` = `s & ~s_d`.
  - `fall` = `~s & s_d`.
- FSM states: IDLE, HIGH, LOW.
  - IDLE: on `rise` go to HIGH with `hi_cnt`=1. Other inputs are ignored. The partial period is discarded and no report is made.
  - HIGH:
    - each cycle with `s`=1, `hi_cnt`++ (saturating).
    - on `fall` go to LOW with `lo_cnt`=1.
  - LOW:
    - each cycle with `s`=0, `lo_cnt`++ (saturating).
    - on `rise`:
      - load `hi_o`=`hi_cnt` and `lo_o`=`lo_cnt`.
      - set `ovf_o` to (either count == 2^WIDTH−1).
      - pulse `valid_o`.
      - go to HIGH with `hi_cnt`=1.
- A period is measured rising edge to rising edge. The first report needs two rising edges and one falling edge after entering HIGH.
- Saturation: counters stop at 2^WIDTH−1 and never wrap. `stuck_o`=1 while the active-phase counter equals 2^WIDTH−1. It clears on the next edge.
- Constant 0% or 100% input: no `valid_o` is produced. `stuck_o` asserts after 2^WIDTH−1 cycles in the phase.
- `en`=0, sampled synchronously:
  - go to IDLE next cycle and clear the counters.
  - `valid_o`=0 and `stuck_o`=0.
  - `hi_o`/`lo_o`/`ovf_o` hold their last values.
  - the synchroniser keeps running.
- `en` deasserted mid-period: the period is discarded. After re-enable, reporting resumes from the next full period.
- Reset values: state IDLE, counters 0, all sync flops 0, `hi_o`=0, `lo_o`=0, `valid_o`=0, `ovf_o`=0, `stuck_o`=0.
- Reset asserted mid-period: everything returns to the reset values immediately (asynchronous). No partial report is made.
- Minimum measurable phase: 1 cycle of `s`. Pulses on `pwm_i` shorter than one `clk` period may be lost.
- Loopback contract: `pwm` driving high for `hi` cycles and low for `lo` cycles yields `hi_o`=`hi` and `lo_o`=`lo` exactly.

## Timing
- Latency: `valid_o` is high in the cycle after the (SYNC_STAGES+1)th `clk` edge following a `pwm_i` rising transition. This is the rising edge that closes the period.
- `valid_o` is exactly one cycle wide. The minimum spacing between strobes equals the period, which is at least 2 cycles.
- Outputs are registered; there is no combinational path from inputs to outputs.
- `rise` and `en`=0 in the same cycle: `en` wins, so no report is made and the state goes to IDLE.

## Structure
- `pwm_pkg`: FSM state enum (IDLE/HIGH/LOW) and the default `WIDTH` constant, shared with `pwm`.
- Sub-module `pwm_sync_edge`: parameterised synchroniser plus the `s_d` flop. Outputs `s`, `rise`, `fall`. It is reused wherever the codebase ingests an asynchronous PWM.
- Top level: FSM, two saturating counters, output registers.

## Test plan
- Reset held for 100 ns, `en`=0 → all outputs 0. There is no `valid_o` while `pwm_i` toggles.
- Loopback from `pwm` with `hi`=5, `lo`=11, `en`=1 → first `valid_o` appears after the second rising edge; then `hi_o`=5, `lo_o`=11, `ovf_o`=0 on every period (one strobe every 16 cycles).
- Change `pwm` to `hi`=8, `lo`=12 mid-run → reports of 8/12 once a full new period completes. At most one transitional report; no report carries a count outside [1,12].
- Direct drive of 1 cycle high, 1 cycle low → `hi_o`=1, `lo_o`=1, with `valid_o` every 2 cycles.
- `WIDTH`=8, `pwm_i` held high for 300 cycles and then toggled → `stuck_o` rises after 255 cycles in HIGH. The next report has `hi_o`=255 and `ovf_o`=1. `stuck_o` clears on the falling edge.
- Drop `en` for 3 cycles mid-LOW, then restore with `hi`=2, `lo`=8 → no report for the interrupted period. The next reports are 2/8. `hi_o`/`lo_o` hold their previous values while `en`=0.
